// File: rtl/qpi_flash_writer.sv
// qpi_flash_writer
//   Issues a QPI (4-bit) write-enable, then either a byte-program or a 4 KB
//   sector-erase, then polls the status register until WIP clears or the
//   poll budget runs out. The flash must already be in QPI mode.
//
// Parameters
//   CS_GAP    cs-high cycles between chained commands (1..15)
//   POLL_MAX  status polls allowed before the operation is flagged as timed out
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   write               start request (accepted only when idle)
//   op                  0 = byte program, 1 = sector erase
//   addr[23:0]          flash byte address
//   wdata[7:0]          program byte (unused for erase)
//   busy                request accepted, operation in flight
//   ready               one-cycle completion pulse
//   err                 last operation timed out polling WIP
//   status[7:0]         last status byte read back
//   cs                  flash chip select, active low
//   di, do_, wp, hold   QPI lanes, {hold,wp,do_,di} = nibble[3:0]
//                       (the second lane is do_ because "do" is a reserved word)
module qpi_flash_writer #(
    parameter int CS_GAP   = 2,
    parameter int POLL_MAX = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        op,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [7:0]  status,
    output logic        cs,
    inout  wire         di,
    inout  wire         do_,
    inout  wire         wp,
    inout  wire         hold
);

    localparam int PCW = ($clog2(POLL_MAX + 1) > 21) ? $clog2(POLL_MAX + 1) : 21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_OPER,
        S_POLL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             cs_q, cs_d;
    logic             oe_q, oe_d;
    logic [39:0]      sh_q, sh_d;        // frame nibbles, current one in [39:36]
    logic [3:0]       cnt_q, cnt_d;      // cs-low cycle number, or gap cycle number
    logic             to_oper_q, to_oper_d;
    logic             op_q, op_d;
    logic [23:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [7:0]       status_q, status_d;
    logic [3:0]       stat_hi_q, stat_hi_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;

    logic [3:0]       lanes_in;
    logic [3:0]       len;
    logic [PCW-1:0]   poll_inc;

    assign lanes_in = {hold, wp, do_, di};
    assign poll_inc = poll_cnt_q + PCW'(1);

    // Lanes are released whenever oe_q is low, which covers cs-high and the
    // two status-read cycles of a poll.
    assign di   = oe_q ? sh_q[36] : 1'bz;
    assign do_  = oe_q ? sh_q[37] : 1'bz;
    assign wp   = oe_q ? sh_q[38] : 1'bz;
    assign hold = oe_q ? sh_q[39] : 1'bz;

    assign cs     = cs_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign status = status_q;
    assign ready  = (state_q == S_DONE);

    // cs-low length of the frame currently on the bus
    always_comb begin
        case (state_q)
            S_WREN:  len = 4'd2;
            S_OPER:  len = op_q ? 4'd8 : 4'd10;
            default: len = 4'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        oe_d       = oe_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        to_oper_d  = to_oper_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        err_d      = err_q;
        status_d   = status_q;
        stat_hi_d  = stat_hi_q;
        poll_cnt_d = poll_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (write) begin
                    op_d       = op;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    cs_d       = 1'b0;
                    oe_d       = 1'b1;
                    sh_d       = {8'h06, 32'h0};
                    cnt_d      = 4'd1;
                    state_d    = S_WREN;
                end
            end

            S_WREN, S_OPER, S_POLL: begin
                if (state_q == S_POLL && cnt_q == 4'd3)
                    stat_hi_d = lanes_in;
                if (cnt_q == len) begin
                    cs_d  = 1'b1;
                    oe_d  = 1'b0;
                    cnt_d = 4'd1;
                    case (state_q)
                        S_WREN: begin
                            to_oper_d = 1'b1;
                            state_d   = S_GAP;
                        end
                        S_OPER: begin
                            to_oper_d = 1'b0;
                            state_d   = S_GAP;
                        end
                        default: begin
                            // end of a poll: low nibble is on the lanes now
                            status_d   = {stat_hi_q, lanes_in};
                            poll_cnt_d = poll_inc;
                            to_oper_d  = 1'b0;
                            if (!lanes_in[0]) begin
                                state_d = S_DONE;
                            end else if (poll_inc >= PCW'(POLL_MAX)) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_GAP;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    sh_d  = {sh_q[35:0], 4'h0};
                    // poll cycles 3 and 4 belong to the flash
                    oe_d  = !(state_q == S_POLL && cnt_q >= 4'd2);
                end
            end

            S_GAP: begin
                if (cnt_q == 4'(CS_GAP)) begin
                    cs_d  = 1'b0;
                    oe_d  = 1'b1;
                    cnt_d = 4'd1;
                    if (to_oper_q) begin
                        state_d = S_OPER;
                        sh_d    = op_q ? {8'h20, addr_q, 8'h00} : {8'h02, addr_q, wdata_q};
                    end else begin
                        state_d = S_POLL;
                        sh_d    = {8'h05, 32'h0};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cs_q       <= 1'b1;
            oe_q       <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            to_oper_q  <= 1'b0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            status_q   <= '0;
            stat_hi_q  <= '0;
            poll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            oe_q       <= oe_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            to_oper_q  <= to_oper_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            status_q   <= status_d;
            stat_hi_q  <= stat_hi_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

endmodule
